// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one word request at a time, waits LATENCY
// cycles, then accesses an internal byte-lane array and pulses a one-cycle response.
module mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_req_ready,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_busy
);

  // state | meaning
  // IDLE  | ready for a request (req_ready high one edge after reset release)
  // WAIT  | request captured, counting down wait cycles; access when cnt hits 0
  // RESP  | resp_valid pulse cycle; back to IDLE on the next edge
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WORD_BITS = ADDR_BITS - 2;
  localparam int NUM_WORDS = 2 ** WORD_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic                   r_req_ready;
  logic                   r_resp_valid;
  logic [31:0]            r_resp_rdata;
  logic                   r_busy;
  logic                   r_write;
  logic [WORD_BITS-1:0]   r_word;
  logic [31:0]            r_wdata;
  logic [3:0]             r_be;
  logic [31:0]            r_mem [NUM_WORDS];

  state_t                 w_state_nxt;
  logic [3:0]             w_cnt_nxt;
  logic                   w_req_ready_nxt;
  logic                   w_resp_valid_nxt;
  logic [31:0]            w_resp_rdata_nxt;
  logic                   w_busy_nxt;
  logic                   w_capture;
  logic                   w_access;
  logic [31:0]            w_stored;
  logic [31:0]            w_merged;
  logic                   w_unused_addr;

  // Only the word index inside the array is meaningful; the rest of the address aliases.
  assign w_unused_addr = ^{i_req_addr[31:ADDR_BITS], i_req_addr[1:0]};

  assign w_stored = r_mem[r_word];

  always_comb begin
    w_merged = w_stored;
    for (int k = 0; k < 4; k++) begin
      if (r_write && r_be[k]) begin
        w_merged[8*k +: 8] = r_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_req_ready_nxt  = r_req_ready;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = r_resp_rdata;
    w_busy_nxt       = r_busy;
    w_capture        = 1'b0;
    w_access         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (r_req_ready && i_req_valid) begin
          w_capture       = 1'b1;
          w_cnt_nxt       = CNT_LOAD;
          w_req_ready_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_access         = 1'b1;
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = w_merged;
          w_state_nxt      = ST_RESP;
        end
      end
      ST_RESP: begin
        w_busy_nxt      = 1'b0;
        w_req_ready_nxt = 1'b1;
        w_state_nxt     = ST_IDLE;
      end
      default: begin
        w_cnt_nxt       = 4'd0;
        w_busy_nxt      = 1'b0;
        w_req_ready_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_write <= 1'b0;
      r_word  <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
    end else if (w_capture) begin
      r_write <= i_req_write;
      r_word  <= i_req_addr[ADDR_BITS-1:2];
      r_wdata <= i_req_wdata;
      r_be    <= i_req_be;
    end
  end

  // Array has no reset so completed writes survive a reset pulse.
  always_ff @(posedge i_clk) begin
    if (w_access && r_write) begin
      r_mem[r_word] <= w_merged;
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_busy       = r_busy;

endmodule
